// File: rtl/multi_cycle_control.sv
// multi_cycle_control: control unit of a multi-cycle MIPS-like CPU.
// A single state register walks each instruction through IF/ID/EXE/MEM/WB.
// Every strobe and select is a combinational function of the current state
// and opCode. Reset forces state and all outputs to zero at once.
//
// Ports:
//   CLK, Reset      clock; asynchronous active-high reset
//   opCode[5:0]     instruction opcode, stable from ID until the next IF
//   zero, sign      ALU flags (sign is not used by this block)
//   PCWre, IRWre, InsMemRW, RegWre, mRD, mWR    write/read strobes
//   ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel datapath selects
//   PCSrc[1:0]      00 PC+4, 01 branch target, 10 jump target
//   ALUOp[2:0]      000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
//   state[3:0]      current FSM state for debug
module multi_cycle_control #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       RegDst,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_L   = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  state_t state_q, state_d;

  // sign is part of the interface but carries no function here.
  logic sign_unused;
  assign sign_unused = sign;

  // Opcode decode
  logic       is_al, is_ls, is_lw, is_br, is_beq, is_j, is_halt;
  logic       dec_srca, dec_srcb, dec_regdst, dec_ext;
  logic [2:0] dec_aluop;

  always_comb begin
    is_al      = 1'b0;
    is_ls      = 1'b0;
    is_lw      = 1'b0;
    is_br      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    dec_srca   = 1'b0;
    dec_srcb   = 1'b0;
    dec_regdst = 1'b0;
    dec_ext    = 1'b1;
    dec_aluop  = 3'b000;
    case (opCode)
      6'b000000: begin is_al = 1'b1; dec_regdst = 1'b1; dec_aluop = 3'b000; end // add
      6'b000001: begin is_al = 1'b1; dec_regdst = 1'b1; dec_aluop = 3'b001; end // sub
      6'b000010: begin is_al = 1'b1; dec_srcb   = 1'b1; dec_aluop = 3'b000; end // addi
      6'b010000: begin is_al = 1'b1; dec_regdst = 1'b1; dec_aluop = 3'b011; end // or
      6'b010001: begin is_al = 1'b1; dec_regdst = 1'b1; dec_aluop = 3'b100; end // and
      6'b010010: begin                                                         // ori
        is_al = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b0; dec_aluop = 3'b011;
      end
      6'b011000: begin                                                         // sll
        is_al = 1'b1; dec_regdst = 1'b1; dec_srca = 1'b1; dec_aluop = 3'b010;
      end
      6'b011100: begin is_al = 1'b1; dec_srcb = 1'b1; dec_aluop = 3'b101; end  // slti
      6'b100110: begin is_ls = 1'b1; dec_srcb = 1'b1; end                      // sw
      6'b100111: begin is_ls = 1'b1; is_lw = 1'b1; dec_srcb = 1'b1; end        // lw
      6'b110000: begin is_br = 1'b1; is_beq = 1'b1; dec_aluop = 3'b001; end    // beq
      6'b110001: begin is_br = 1'b1; dec_aluop = 3'b001; end                   // bne
      6'b111000: is_j = 1'b1;                                                  // j
      default: ;
    endcase
  end

  assign is_halt = (opCode == HALT_OP);

  // Next state
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        if (is_j)         state_d = S_IF;
        else if (is_halt) state_d = S_HALT;
        else if (is_br)   state_d = S_EXE_BR;
        else if (is_ls)   state_d = S_EXE_LS;
        else if (is_al)   state_d = S_EXE_AL;
        else              state_d = S_IF;   // undefined opcode: 2-cycle nop
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_L : S_IF;
      S_WB_L:   state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Outputs. Reset gates everything because state_q==IF would otherwise
  // raise IRWre/InsMemRW while Reset is still held.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    RegDst    = 1'b0;
    ExtSel    = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    if (!Reset) begin
      // Per-opcode selects hold from EXE through the last state of the instr.
      if (state_q inside {S_EXE_LS, S_MEM, S_WB_L, S_EXE_BR, S_EXE_AL, S_WB_AL}) begin
        ALUSrcA = dec_srca;
        ALUSrcB = dec_srcb;
        RegDst  = dec_regdst;
        ExtSel  = dec_ext;
        ALUOp   = dec_aluop;
      end
      case (state_q)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          if (is_j) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end else if (!is_halt && !is_br && !is_ls && !is_al) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          if ((is_beq && zero) || (!is_beq && !zero)) PCSrc = 2'b01;
        end
        S_MEM: begin
          if (is_lw) mRD = 1'b1;
          else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_L: begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          RegWre    = 1'b1;
          PCWre     = 1'b1;
        end
        S_WB_AL: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter HALT_OP, default 6'b111111; opcode that enters the halt state.
REQ-002 CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 opCode  input  6  opcode of the instruction register; stable from the first ID cycle until the next IF.
REQ-005 zero  input  1  ALU result==0; sign  input  1  ALU result negative (reserved; no function in this block).
REQ-006 PCWre, IRWre, InsMemRW, RegWre, mRD, mWR  output  1 each  PC write, IR load, instruction read, register write, data read, data write strobes.
REQ-007 ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel  output  1 each  datapath mux/extend selects: 1 = sa, 1 = extended immediate, 1 = RAM data, 1 = rd, 1 = sign-extend.
REQ-008 PCSrc  output  2  00 = PC+4, 01 = PC+4+(ext<<2), 10 = jump target.
REQ-009 ALUOp  output  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 signed less-than.
REQ-010 state  output  4  current FSM state, for display/debug.

Function
REQ-011 The FSM SHALL have the states IF=0000, ID=0001, EXE_LS=0010, MEM=0011, WB_L=0100, EXE_BR=0101, EXE_AL=0110, WB_AL=0111, HALT=1000; all outputs SHALL be combinational functions of the state and opCode.
REQ-012 Opcodes SHALL be: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slti 011100, sw 100110, lw 100111, beq 110000, bne 110001, j 111000, halt = HALT_OP.
REQ-013 IF: InsMemRW=1, IRWre=1; all other outputs 0; next state ID.
REQ-014 ID: j -> PCWre=1, PCSrc=10, next IF; halt -> HALT; beq/bne -> EXE_BR; lw/sw -> EXE_LS; arithmetic/logic -> EXE_AL.
REQ-015 ID with an undefined opcode: PCWre=1, PCSrc=00, next IF (treated as a nop, 2 cycles).
REQ-016 EXE_AL -> WB_AL; in WB_AL, RegWre=1, PCWre=1, PCSrc=00, DBDataSrc=0; next IF.
REQ-017 EXE_BR: ALUOp=001, PCWre=1; PCSrc=01 when (beq & zero) | (bne & ~zero), else 00; next IF.
REQ-018 EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1; next MEM.
REQ-019 MEM with sw: mWR=1, PCWre=1, PCSrc=00, next IF; MEM with lw: mRD=1, next WB_L.
REQ-020 WB_L: mRD=1, DBDataSrc=1, RegWre=1, RegDst=0, PCWre=1, PCSrc=00; next IF.
REQ-021 Per-opcode selects SHALL be held from the EXE state through the final state of the instruction, and SHALL be 0 in IF, ID and HALT: RegDst=1 for add/sub/or/and/sll; ALUSrcA=1 for sll; ALUSrcB=1 for addi/ori/slti/lw/sw; ExtSel=0 for ori, else 1; ALUOp per REQ-009 (addi/lw/sw add, beq/bne sub, ori or, slti slt).
REQ-022 PCWre, RegWre and mWR SHALL each be high for at most one cycle per instruction.
REQ-023 Cycles per instruction SHALL be: j 2, beq/bne 3, R-type/immediate 4, sw 4, lw 5.
REQ-024 HALT: all outputs 0; the FSM SHALL stay in HALT regardless of opCode and zero until Reset.

Reset
REQ-025 While Reset=1: state=0000 and every output=0 (IRWre and InsMemRW included). This takes effect immediately and asynchronously, in any state, including mid-instruction.
REQ-026 Reset de-asserted: the first rising edge of CLK SHALL be evaluated as IF (state 0000 -> 0001).

Verification
REQ-027 add (000000) from reset: states 0000, 0001, 0110, 0111, 0000; RegDst=1 and ALUOp=000 in 0110-0111; RegWre=PCWre=1 only in 0111.
REQ-028 beq with zero=1: states 0000, 0001, 0101 with PCSrc=01, PCWre=1; repeat with zero=0 -> PCSrc=00; bne with zero=0 -> PCSrc=01.
REQ-029 lw (100111): 5 cycles; mRD=1 in 0011 and 0100; DBDataSrc=RegWre=1, RegDst=0 only in 0100. sw (100110): mWR=1 and PCWre=1 in 0011, then 0000.
REQ-030 j (111000): state 0001 with PCSrc=10 and PCWre=1, then 0000; undefined opcode 101010: PCSrc=00 and PCWre=1 in 0001.
REQ-031 halt (111111): state 1000 and stays there for at least 20 cycles with PCWre=0 while opCode is toggled; Reset pulse -> 0000.
REQ-032 Reset asserted mid-cycle in MEM of lw: state=0000 and mRD=0 before the next edge; no RegWre pulse occurs; after release, a normal IF->ID sequence follows.
